// File: rtl/sound_fx_if.sv
// sound_fx_if: game-state inputs and speaker/busy outputs of the pong sound block.
// Build option: SOUND_MUTE_EN adds a 'mute' input that silences the speaker pin.
//
// Transfer semantics: there is no valid/ready pair. game_tick is a one-clk
// strobe; x, y and both scores are sampled only on clk edges where game_tick
// is 1 and must be stable on those edges. speaker, busy and state_dbg are
// outputs of the sound block and are always valid.
interface sound_fx_if;
    logic       game_tick;
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] score_p1;
    logic [3:0] score_p2;
`ifdef SOUND_MUTE_EN
    logic       mute;
`endif
    logic       speaker;
    logic       busy;
    logic [1:0] state_dbg;

`ifdef SOUND_MUTE_EN
    modport master (
        output game_tick, x, y, score_p1, score_p2, mute,
        input  speaker, busy, state_dbg
    );
    modport slave (
        input  game_tick, x, y, score_p1, score_p2, mute,
        output speaker, busy, state_dbg
    );
`else
    modport master (
        output game_tick, x, y, score_p1, score_p2,
        input  speaker, busy, state_dbg
    );
    modport slave (
        input  game_tick, x, y, score_p1, score_p2,
        output speaker, busy, state_dbg
    );
`endif
endinterface

// File: rtl/sound_fx.sv
// sound_fx: pong sound effects. Watches ball position and scores on each game
// tick, detects wall bounces, paddle bounces and goals, and drives a piezo pin
// with a gated square wave (one tone for bounces, a two-tone jingle for goals).
// Build option: SOUND_MUTE_EN adds bus.mute, which gates the speaker pin only.
// state_dbg exposes the FSM state: 0 IDLE, 1 BOUNCE, 2 GOAL_HI, 3 GOAL_LO.
module sound_fx #(
    parameter int HALF_WALL    = 2500,
    parameter int HALF_PADDLE  = 1250,
    parameter int HALF_GOAL_HI = 833,
    parameter int HALF_GOAL_LO = 1667,
    parameter int DUR_BOUNCE   = 40,
    parameter int DUR_GOAL     = 150,
    parameter int CNTW         = 16
) (
    input  logic       clk,
    input  logic       reset,
    sound_fx_if.slave  bus
);

    // Duration counter is sized for the longer of the two tone lengths.
    localparam int DUR_MAX = (DUR_GOAL > DUR_BOUNCE) ? DUR_GOAL : DUR_BOUNCE;
    localparam int DURW    = $clog2(DUR_MAX + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BOUNCE  = 2'd1,
        GOAL_HI = 2'd2,
        GOAL_LO = 2'd3
    } state_t;

    // Last nonzero movement direction along one axis; NONE means unknown.
    typedef enum logic [1:0] {
        DIR_NONE = 2'b00,
        DIR_POS  = 2'b01,
        DIR_NEG  = 2'b10
    } dir_t;

    // History of the previous tick.
    logic [3:0] prev_x, prev_y, prev_p1, prev_p2;
    logic       hist_valid;
    dir_t       dirx, diry;

    // Tone engine state.
    state_t            state, state_nx;
    logic [DURW-1:0]   dur_cnt, dur_nx;
    logic [CNTW-1:0]   half_sel, half_nx;
    logic [CNTW-1:0]   half_cnt, cnt_nx;
    logic              wave, wave_nx;
    logic              busy_q;
    logic              restart;

    // Per-tick event decode.
    dir_t step_x, step_y;
    dir_t dirx_nx, diry_nx;
    logic goal_ev, paddle_ev, wall_ev;
    logic score_chg, score_zero;

    // A reversal needs both a real move now and a known previous direction.
    function automatic logic reverses(input dir_t step, input dir_t last);
        return (step != DIR_NONE) && (last != DIR_NONE) && (step != last);
    endfunction

    // Decode goal / paddle / wall events against the stored history.
    always_comb begin
        step_x = DIR_NONE;
        step_y = DIR_NONE;
        if (bus.x > prev_x)      step_x = DIR_POS;
        else if (bus.x < prev_x) step_x = DIR_NEG;
        if (bus.y > prev_y)      step_y = DIR_POS;
        else if (bus.y < prev_y) step_y = DIR_NEG;

        score_chg  = (bus.score_p1 != prev_p1) || (bus.score_p2 != prev_p2);
        score_zero = (bus.score_p1 == 4'd0) && (bus.score_p2 == 4'd0);

        // Priority GOAL > PADDLE > WALL; nothing fires until history is valid.
        goal_ev   = hist_valid && score_chg && !score_zero;
        paddle_ev = hist_valid && !goal_ev && reverses(step_x, dirx);
        wall_ev   = hist_valid && !goal_ev && !paddle_ev && reverses(step_y, diry);

        // First tick after reset/goal forgets direction; zero deltas keep it.
        dirx_nx = dirx;
        diry_nx = diry;
        if (!hist_valid) begin
            dirx_nx = DIR_NONE;
            diry_nx = DIR_NONE;
        end else begin
            if (step_x != DIR_NONE) dirx_nx = step_x;
            if (step_y != DIR_NONE) diry_nx = step_y;
        end
    end

    // History registers: loaded on every tick; a goal invalidates them so the
    // ball respawn jump is never seen as a bounce.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_x     <= '0;
            prev_y     <= '0;
            prev_p1    <= '0;
            prev_p2    <= '0;
            hist_valid <= 1'b0;
            dirx       <= DIR_NONE;
            diry       <= DIR_NONE;
        end else if (bus.game_tick) begin
            prev_x     <= bus.x;
            prev_y     <= bus.y;
            prev_p1    <= bus.score_p1;
            prev_p2    <= bus.score_p2;
            hist_valid <= !goal_ev;
            dirx       <= dirx_nx;
            diry       <= diry_nx;
        end
    end

    // Effect FSM: start/retrigger tones on events, count duration in ticks.
    always_comb begin
        state_nx = state;
        dur_nx   = dur_cnt;
        half_nx  = half_sel;
        restart  = 1'b0;
        if (bus.game_tick) begin
            if (goal_ev) begin
                state_nx = GOAL_HI;
                dur_nx   = DURW'(DUR_GOAL);
                half_nx  = CNTW'(HALF_GOAL_HI);
                restart  = 1'b1;
            end else if ((paddle_ev || wall_ev) &&
                         (state == IDLE || state == BOUNCE)) begin
                state_nx = BOUNCE;
                dur_nx   = DURW'(DUR_BOUNCE);
                half_nx  = paddle_ev ? CNTW'(HALF_PADDLE) : CNTW'(HALF_WALL);
                restart  = 1'b1;
            end else if (state != IDLE) begin
                // Expiry happens on the tick that takes the count from 1 to 0.
                dur_nx = dur_cnt - 1'b1;
                if (dur_cnt == DURW'(1)) begin
                    if (state == GOAL_HI) begin
                        state_nx = GOAL_LO;
                        dur_nx   = DURW'(DUR_GOAL);
                        half_nx  = CNTW'(HALF_GOAL_LO);
                        restart  = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
        end
    end

    // Square wave: phase-aligned restart (high, count 0) on every tone entry,
    // silent and held at 0 in IDLE, otherwise toggle when the count wraps.
    always_comb begin
        cnt_nx  = half_cnt + 1'b1;
        wave_nx = wave;
        if (restart) begin
            cnt_nx  = '0;
            wave_nx = 1'b1;
        end else if (state_nx == IDLE) begin
            cnt_nx  = '0;
            wave_nx = 1'b0;
        end else if (half_cnt == half_sel - 1'b1) begin
            cnt_nx  = '0;
            wave_nx = ~wave;
        end
    end

    // Tone engine registers; reset wins over any tone in progress.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            dur_cnt  <= '0;
            half_sel <= '0;
            half_cnt <= '0;
            wave     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            dur_cnt  <= dur_nx;
            half_sel <= half_nx;
            half_cnt <= cnt_nx;
            wave     <= wave_nx;
            busy_q   <= (state_nx != IDLE);
        end
    end

    assign bus.busy      = busy_q;
    assign bus.state_dbg = state;

`ifdef SOUND_MUTE_EN
    // Mute only gates the pin; the wave keeps running so un-muting resumes phase.
    assign bus.speaker = wave & ~bus.mute;
`else
    assign bus.speaker = wave;
`endif

endmodule

// File: tb/tb_sound_fx.sv
// tb_sound_fx: directed pong scenarios against a tick-level behavioural model
// of the sound effects; speaker and busy are compared on every clock.
module tb_sound_fx;

    // Small tone/duration values keep the run short while staying distinct.
    localparam int HW  = 5;
    localparam int HP  = 3;
    localparam int HGH = 2;
    localparam int HGL = 4;
    localparam int DB  = 8;
    localparam int DG  = 6;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    sound_fx_if bus();

    sound_fx #(
        .HALF_WALL(HW), .HALF_PADDLE(HP), .HALF_GOAL_HI(HGH),
        .HALF_GOAL_LO(HGL), .DUR_BOUNCE(DB), .DUR_GOAL(DG), .CNTW(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 silent, 1 bounce, 2 goal high tone, 3 goal low tone.
    int cyc     = 0;
    int m_mode  = 0;
    int m_left  = 0;
    int m_half  = 1;
    int m_start = 0;
    bit m_valid = 0;
    int m_dx    = 0;
    int m_dy    = 0;
    int hx = 0, hy = 0, hp1 = 0, hp2 = 0;

    function automatic int sgn(input int v);
        return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
    endfunction

    task automatic tone(input int mode, input int half, input int dur);
        m_mode  = mode;
        m_half  = half;
        m_left  = dur;
        m_start = cyc;
    endtask

    task automatic model_step();
        bit goal, pad, wall;
        int sx, sy;
        cyc++;
        if (!reset) begin
            m_mode  = 0;
            m_left  = 0;
            m_valid = 0;
            m_dx    = 0;
            m_dy    = 0;
        end else if (bus.game_tick) begin
            goal = 0; pad = 0; wall = 0;
            sx = sgn(int'(bus.x) - hx);
            sy = sgn(int'(bus.y) - hy);
            if (m_valid) begin
                goal = (int'(bus.score_p1) != hp1 || int'(bus.score_p2) != hp2) &&
                       !(bus.score_p1 == 0 && bus.score_p2 == 0);
                pad  = !goal && sx != 0 && sx == -m_dx;
                wall = !goal && !pad && sy != 0 && sy == -m_dy;
                if (sx != 0) m_dx = sx;
                if (sy != 0) m_dy = sy;
            end else begin
                m_dx = 0;
                m_dy = 0;
            end
            hx  = int'(bus.x);
            hy  = int'(bus.y);
            hp1 = int'(bus.score_p1);
            hp2 = int'(bus.score_p2);
            m_valid = !goal;
            if (goal) tone(2, HGH, DG);
            else if ((pad || wall) && m_mode <= 1) tone(1, pad ? HP : HW, DB);
            else if (m_mode != 0) begin
                m_left--;
                if (m_left == 0) begin
                    if (m_mode == 2) tone(3, HGL, DG);
                    else m_mode = 0;
                end
            end
        end
    endtask

    // ---------------- scoreboard: every clock ----------------
    always @(posedge clk) begin
        logic exp_busy, exp_spk;
        model_step();
        #1;
        exp_busy = (m_mode != 0);
        exp_spk  = (m_mode != 0) && (((cyc - m_start) / m_half) % 2 == 0);
`ifdef SOUND_MUTE_EN
        if (bus.mute) exp_spk = 1'b0;
`endif
        check("busy", {31'd0, bus.busy}, {31'd0, exp_busy});
        check("speaker", {31'd0, bus.speaker}, {31'd0, exp_spk});
    end

    // ---------------- driver tasks ----------------
    logic [3:0] cx = 4'd8, cy = 4'd3, c1 = 4'd0, c2 = 4'd0;

    task automatic do_tick(input logic [3:0] nx, input logic [3:0] ny,
                           input logic [3:0] np1, input logic [3:0] np2);
        cx = nx; cy = ny; c1 = np1; c2 = np2;
        @(negedge clk);
        bus.x = cx; bus.y = cy; bus.score_p1 = c1; bus.score_p2 = c2;
        bus.game_tick = 1'b1;
        @(negedge clk);
        bus.game_tick = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) do_tick(cx, cy, c1, c2);
    endtask

    // Ticks with unchanged inputs until busy drops; bounded.
    task automatic count_busy(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 64) begin
            hold(1);
            n++;
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int n;
        bus.game_tick = 1'b0;
        bus.x = cx; bus.y = cy; bus.score_p1 = c1; bus.score_p2 = c2;
`ifdef SOUND_MUTE_EN
        bus.mute = 1'b0;
`endif
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_speaker", {31'd0, bus.speaker}, 32'd0);

        // Wall bounce: y 3,4,5,4 with x fixed.
        do_tick(8, 3, 0, 0);
        do_tick(8, 4, 0, 0);
        do_tick(8, 5, 0, 0);
        check("wall_pre_busy", {31'd0, bus.busy}, 32'd0);
        do_tick(8, 4, 0, 0);
        check("wall_busy", {31'd0, bus.busy}, 32'd1);
        check("wall_speaker", {31'd0, bus.speaker}, 32'd1);
        check("wall_mode_pin", m_mode, 32'd1);
        check("wall_half_pin", m_half, 32'd5);
        count_busy(n);
        check("wall_len", n, 32'd8);

        // Paddle wins over a simultaneous wall reversal.
        do_tick(12, 4, 0, 0);
        do_tick(13, 3, 0, 0);
        do_tick(14, 2, 0, 0);
        do_tick(13, 3, 0, 0);
        check("pad_busy", {31'd0, bus.busy}, 32'd1);
        check("pad_speaker", {31'd0, bus.speaker}, 32'd0);
        check("pad_half_pin", m_half, 32'd3);
        count_busy(n);
        check("pad_len", n, 32'd8);

        // Paddle, then a wall bounce 5 ticks later restarts the tone.
        do_tick(14, 3, 0, 0);
        check("retrig_pad_busy", {31'd0, bus.busy}, 32'd1);
        hold(4);
        do_tick(14, 2, 0, 0);
        check("retrig_wall_speaker", {31'd0, bus.speaker}, 32'd1);
        check("retrig_half_pin", m_half, 32'd5);
        count_busy(n);
        check("retrig_len", n, 32'd8);

        // Goal jingle; respawn jump ignored, wall during GOAL_LO ignored.
        do_tick(14, 2, 1, 0);
        check("goal_busy", {31'd0, bus.busy}, 32'd1);
        check("goal_mode_pin", m_mode, 32'd2);
        do_tick(7, 2, 1, 0);
        do_tick(7, 3, 1, 0);
        hold(4);
        check("goal_lo_pin", m_mode, 32'd3);
        check("goal_lo_busy", {31'd0, bus.busy}, 32'd1);
        hold(1);
        do_tick(7, 2, 1, 0);
        check("goal_lo_ignore_pin", m_left, 32'd4);
        hold(3);
        check("goal_lo_end_busy", {31'd0, bus.busy}, 32'd1);
        hold(1);
        check("goal_done_busy", {31'd0, bus.busy}, 32'd0);

        // Scores 3/2 (a goal), then 0/0 is a silent game reset.
        do_tick(7, 2, 3, 2);
        check("goal2_busy", {31'd0, bus.busy}, 32'd1);
        hold(13);
        check("goal2_done", {31'd0, bus.busy}, 32'd0);
        do_tick(7, 2, 0, 0);
        check("zero_score_busy", {31'd0, bus.busy}, 32'd0);
        hold(2);
        check("zero_score_busy2", {31'd0, bus.busy}, 32'd0);

        // Reset in the middle of GOAL_HI.
        do_tick(7, 2, 1, 0);
        hold(2);
        check("pre_reset_busy", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("midreset_busy", {31'd0, bus.busy}, 32'd0);
        check("midreset_speaker", {31'd0, bus.speaker}, 32'd0);
        do_tick(3, 9, 2, 0);
        check("post_reset_load", {31'd0, bus.busy}, 32'd0);

`ifdef SOUND_MUTE_EN
        // Muted paddle bounce, then un-mute mid-tone.
        do_tick(4, 9, 2, 0);
        @(negedge clk);
        bus.mute = 1'b1;
        do_tick(3, 9, 2, 0);
        check("mute_busy", {31'd0, bus.busy}, 32'd1);
        check("mute_speaker", {31'd0, bus.speaker}, 32'd0);
        hold(2);
        bus.mute = 1'b0;
        count_busy(n);
        check("mute_len", n, 32'd6);
`endif

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
